ant_move_sequencer: RTL and testbench

Step-level controller between the `ant_suit` behaviour block and the maze/actuator model. It paces the ant one move at a time: waits for antenna/hit/escape sensors to settle, samples the suit's combinational `move` request, and issues it to the actuator over a valid/ready handshake. It overrides the suit with a forced right turn after a wall hit, stops on escape, and enforces a step budget. Registers sit between the suit's combinational `move` and the actuator; `ant_suit` itself is unchanged.

---
 rtl/ant_move_sequencer_pkg.sv | 25 ++
 rtl/ant_step_counter.sv | 36 +++
 rtl/ant_move_sequencer.sv | 121 ++++++++++++
 tb/tb_ant_move_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ant_move_sequencer_pkg.sv
// Shared definitions for the ant move sequencer: move codes and FSM states.
package ant_move_sequencer_pkg;

    // Move codes shared with ant_suit and the actuator.
    typedef enum logic [1:0] {
        HALT    = 2'd0,
        RIGHT   = 2'd1,
        LEFT    = 2'd2,
        FORWARD = 2'd3
    } move_e;

    // Sequencer FSM state encoding.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSettle  = 3'd1,
        StIssue   = 3'd2,
        StBackoff = 3'd3,
        StDone    = 3'd4,
        StTimeout = 3'd5
    } state_e;

    // Width of the settle-phase counter; covers SETTLE_CYC up to 15.
    localparam int unsigned SettleCntW = 4;

endpackage

// File: rtl/ant_step_counter.sv
// Per-run step and wall-hit counters with budget-reached compare.
module ant_step_counter #(
    parameter int unsigned STEP_W    = 10,
    parameter int unsigned MAX_STEPS = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step_inc,
    input  logic              hit_inc,
    output logic [STEP_W-1:0] step_count,
    output logic [7:0]        hit_count,
    output logic              budget_hit
);

    // Counters clear on run start; hit_count saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
            hit_count  <= '0;
        end else if (clr) begin
            step_count <= '0;
            hit_count  <= '0;
        end else begin
            if (step_inc) begin
                step_count <= step_count + 1'b1;
            end
            if (hit_inc && (hit_count != 8'hFF)) begin
                hit_count <= hit_count + 8'd1;
            end
        end
    end

    assign budget_hit = (step_count == STEP_W'(MAX_STEPS));

endmodule

// File: rtl/ant_move_sequencer.sv
// Paces ant_suit move requests to the actuator one step at a time.
module ant_move_sequencer
    import ant_move_sequencer_pkg::*;
#(
    parameter int unsigned MAX_STEPS  = 1023,
    parameter int unsigned STEP_W     = 10,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        req_move,
    input  logic              hit,
    input  logic              escape,
    output logic [1:0]        cmd_move,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [STEP_W-1:0] step_count,
    output logic [7:0]        hit_count
);

    state_e                state;
    logic [SettleCntW-1:0] settle_cnt;
    logic                  settle_last;
    logic                  can_start;
    logic                  clr;
    logic                  step_inc;
    logic                  hit_inc;
    logic                  budget_hit;

    assign settle_last = (settle_cnt == SettleCntW'(SETTLE_CYC - 1));
    assign can_start   = (state == StIdle) || (state == StDone) || (state == StTimeout);
    assign clr         = start && can_start && !abort;
    // cmd_valid is only ever high in ISSUE/BACKOFF, so it alone qualifies the transfer.
    assign step_inc    = cmd_valid && cmd_ready && !abort;
    assign hit_inc     = (state == StSettle) && settle_last && !escape && hit && !abort;

    ant_step_counter #(
        .STEP_W   (STEP_W),
        .MAX_STEPS(MAX_STEPS)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .step_inc  (step_inc),
        .hit_inc   (hit_inc),
        .step_count(step_count),
        .hit_count (hit_count),
        .budget_hit(budget_hit)
    );

    // Sequencer FSM with registered command and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            settle_cnt <= '0;
            cmd_move   <= HALT;
            cmd_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else if (abort) begin
            // Counters and flags stay for readout.
            state     <= StIdle;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone, StTimeout: begin
                    if (start) begin
                        state      <= StSettle;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                StSettle: begin
                    if (settle_last) begin
                        if (escape) begin
                            state <= StDone;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (hit) begin
                            state     <= StBackoff;
                            cmd_move  <= RIGHT;
                            cmd_valid <= 1'b1;
                        end else if (budget_hit) begin
                            state   <= StTimeout;
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state     <= StIssue;
                            cmd_move  <= req_move;
                            cmd_valid <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StIssue, StBackoff: begin
                    if (cmd_ready) begin
                        state      <= StSettle;
                        settle_cnt <= '0;
                        cmd_valid  <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ant_move_sequencer.sv
// Directed self-checking bench for ant_move_sequencer (MAX_STEPS=4, SETTLE_CYC=2).
module tb_ant_move_sequencer;
    import ant_move_sequencer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] req_move;
    logic       hit;
    logic       escape;
    logic [1:0] cmd_move;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [9:0] step_count;
    logic [7:0] hit_count;

    int checks = 0;
    int errors = 0;

    ant_move_sequencer #(
        .MAX_STEPS (4),
        .STEP_W    (10),
        .SETTLE_CYC(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .req_move  (req_move),
        .hit       (hit),
        .escape    (escape),
        .cmd_move  (cmd_move),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .step_count(step_count),
        .hit_count (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; req_move = HALT; hit = 0; escape = 0; cmd_ready = 0;
        step();
        checks++;
        if ({cmd_move, cmd_valid, busy, done, timeout} !== {HALT, 4'b0000} ||
            step_count !== 10'd0 || hit_count !== 8'd0) begin
            errors++;
            $display("FAIL reset: move=%0d valid=%b busy=%b done=%b to=%b sc=%0d hc=%0d, want all 0",
                     cmd_move, cmd_valid, busy, done, timeout, step_count, hit_count);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Cycle-accurate first two steps with ready tied high.
    task automatic test_basic();
        logic [1:0] exp_valid [1:7];
        exp_valid = '{0, 0, 1, 0, 0, 1, 0};
        req_move = FORWARD; cmd_ready = 1'b1; start = 1'b1;
        step();  // edge 0
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (cmd_valid !== exp_valid[c][0]) begin
                errors++;
                $display("FAIL basic_valid cycle %0d: got %b want %b", c, cmd_valid, exp_valid[c][0]);
            end
            if (c == 3) begin
                checks++;
                if (cmd_move !== FORWARD || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_move: move=%0d busy=%b want %0d/1", cmd_move, busy, FORWARD);
                end
            end
            if (c == 4 || c == 7) begin
                checks++;
                if (step_count !== ((c == 4) ? 10'd1 : 10'd2)) begin
                    errors++;
                    $display("FAIL basic_step_count cycle %0d: got %0d want %0d",
                             c, step_count, (c == 4) ? 1 : 2);
                end
            end
            if (c < 7) step();
        end
        do_abort();
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || step_count !== 10'd2) begin
            errors++;
            $display("FAIL basic_abort_idle: busy=%b valid=%b sc=%0d want 0/0/2",
                     busy, cmd_valid, step_count);
        end
    endtask

    // Back-pressure: ISSUE holds while ready is low and req_move toggles.
    task automatic test_stall();
        req_move = FORWARD; cmd_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();  // cycle 3
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_move !== FORWARD || step_count !== 10'd0) begin
                errors++;
                $display("FAIL stall_hold %0d: valid=%b move=%0d sc=%0d want 1/%0d/0",
                         i, cmd_valid, cmd_move, step_count, FORWARD);
            end
            req_move = (i % 2 == 0) ? LEFT : HALT;
            step();
        end
        cmd_ready = 1'b1;
        step();
        checks++;
        if (cmd_valid !== 1'b0 || step_count !== 10'd1) begin
            errors++;
            $display("FAIL stall_release: valid=%b sc=%0d want 0/1", cmd_valid, step_count);
        end
        do_abort();
    endtask

    // Wall hit forces a right turn and counts a backoff.
    task automatic test_hit();
        req_move = FORWARD; cmd_ready = 1'b1; hit = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();  // cycle 3
        hit = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_move !== RIGHT || hit_count !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_backoff: valid=%b move=%0d hc=%0d busy=%b want 1/%0d/1/1",
                     cmd_valid, cmd_move, hit_count, busy, RIGHT);
        end
        step();
        checks++;
        if (cmd_valid !== 1'b0 || step_count !== 10'd1) begin
            errors++;
            $display("FAIL hit_step: valid=%b sc=%0d want 0/1", cmd_valid, step_count);
        end
        do_abort();
    endtask

    // Escape beats hit; start then clears done.
    task automatic test_escape_hit();
        cmd_ready = 1'b1; escape = 1'b1; hit = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL esc_settle: busy=%b done=%b want 1/0", busy, done);
        end
        step(); step();  // cycle 3
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0 || hit_count !== 8'd0 ||
            step_count !== 10'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL esc_done: done=%b busy=%b valid=%b hc=%0d sc=%0d to=%b want 1/0/0/0/0/0",
                     done, busy, cmd_valid, hit_count, step_count, timeout);
        end
        escape = 1'b0; hit = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL esc_restart: done=%b busy=%b want 0/1", done, busy);
        end
        do_abort();
    endtask

    // Step budget: 4 transfers then TIMEOUT; optional escape at 5th sampling.
    task automatic run_budget(input bit with_escape);
        int transfers = 0;
        int end_cycle = 0;
        req_move = LEFT; cmd_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL budget_clear: done=%b to=%b want 0/0", done, timeout);
        end
        for (int c = 1; c <= 40; c++) begin
            if (cmd_valid === 1'b1) transfers++;
            if (timeout === 1'b1 || done === 1'b1) begin
                end_cycle = c;
                break;
            end
            escape = with_escape && (c == 14);
            step();
        end
        escape = 1'b0;
        checks++;
        if (end_cycle != 15) begin
            errors++;
            $display("FAIL budget_end_cycle esc=%0d: got %0d want 15", with_escape, end_cycle);
        end
        checks++;
        if (transfers != 4 || step_count !== 10'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL budget_count esc=%0d: transfers=%0d sc=%0d busy=%b want 4/4/0",
                     with_escape, transfers, step_count, busy);
        end
        checks++;
        if (timeout !== !with_escape || done !== with_escape) begin
            errors++;
            $display("FAIL budget_flags esc=%0d: to=%b done=%b want %b/%b",
                     with_escape, timeout, done, !with_escape, with_escape);
        end
    endtask

    task automatic test_timeout();
        run_budget(1'b0);
        run_budget(1'b1);
        do_abort();
    endtask

    // Abort during stalled ISSUE, start+abort collision, then async reset mid-run.
    task automatic test_abort_reset();
        req_move = FORWARD; cmd_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: valid=%b want 1", cmd_valid);
        end
        do_abort();
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: valid=%b busy=%b want 0/0", cmd_valid, busy);
        end
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_wins: busy=%b want 0", busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        hit = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_valid: valid=%b want 0", cmd_valid);
        end
        step();
        checks++;
        if ({cmd_move, cmd_valid, busy, done, timeout} !== {HALT, 4'b0000} ||
            step_count !== 10'd0 || hit_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: move=%0d valid=%b busy=%b done=%b to=%b sc=%0d hc=%0d",
                     cmd_move, cmd_valid, busy, done, timeout, step_count, hit_count);
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_hit();
        test_escape_hit();
        test_timeout();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
